mips_run_ctrl: RTL and testbench

Synthesizable run controller for MIPS simulation and FPGA bring-up. It sequences core reset, counts run cycles, and watches each core's store bus for a halt write to a magic address. It reports per-core pass/fail and a global done/timeout, and gates waveform/trace capture to a cycle window. It sits between the board or bench clock/reset and up to NUM_CORES MIPS instances, and replaces fixed-length reset-and-run benches with a parametrised, self-terminating harness.

---
 rtl/mips_run_ctrl.sv | 146 ++++++++++++++
 tb/tb_mips_run_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: run controller for MIPS simulation and FPGA bring-up.
// Holds the cores in reset for a fixed number of cycles and counts run cycles.
// It watches each core's store bus for a write to the halt address, then reports
// per-core exit codes, pass/fail and timeout, and gates a trace window.
//
// Store bus semantics: st_valid[i] is a qualifier-only strobe. There is no
// ready, and the controller samples every strobed store on the rising clock
// edge. A store only has an effect when it targets HALT_ADDR, the core is
// running (not held in reset) and the core has not already halted.
module mips_run_ctrl #(
  parameter int                 RESET_CYCLES = 2,
  parameter int unsigned        MAX_CYCLES   = 5000,
  parameter int                 CNT_W        = 32,
  parameter int                 NUM_CORES    = 1,
  parameter int                 ADDR_W       = 32,
  parameter int                 DATA_W       = 32,
  parameter logic [ADDR_W-1:0]  HALT_ADDR    = ADDR_W'(32'hFFFF_FFF0),
  parameter int unsigned        TRACE_START  = 0,
  parameter int unsigned        TRACE_LEN    = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        st_valid,
  input  logic [NUM_CORES*ADDR_W-1:0] st_addr,
  input  logic [NUM_CORES*DATA_W-1:0] st_data,
  output logic [NUM_CORES-1:0]        core_reset,
  output logic                        running,
  output logic                        done,
  output logic                        timeout,
  output logic [NUM_CORES-1:0]        halted,
  output logic                        pass,
  output logic [NUM_CORES*DATA_W-1:0] exit_code,
  output logic [CNT_W-1:0]            cycle_count,
  output logic                        trace_en,
  output logic [1:0]                  state_dbg
);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last run cycle index allowed by the budget, and last hold count.
  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);
  localparam logic [7:0]       HOLD_LAST  = 8'(RESET_CYCLES - 1);

  // Trace window bounds are one bit wider than the counter so that
  // TRACE_START+TRACE_LEN cannot wrap around.
  localparam logic [CNT_W:0]   WIN_LO = (CNT_W+1)'(TRACE_START);
  localparam logic [CNT_W:0]   WIN_HI = WIN_LO + (CNT_W+1)'(TRACE_LEN);

  state_t                      state;
  logic [7:0]                  hold_cnt;

  logic [NUM_CORES-1:0]        halt_hit;
  logic [NUM_CORES-1:0]        halted_nxt;
  logic [NUM_CORES-1:0]        code_ok;
  logic [NUM_CORES*DATA_W-1:0] exit_code_nxt;
  logic                        all_halted_nxt;
  logic                        codes_ok_nxt;
  logic                        budget_end;
  logic [CNT_W-1:0]            cycle_inc;

  // True when run cycle c lies inside the trace window.
  function automatic logic in_window(input logic [CNT_W-1:0] c);
    logic [CNT_W:0] ce;
    ce = {1'b0, c};
    return (ce >= WIN_LO) && ((TRACE_LEN == 0) || (ce < WIN_HI));
  endfunction

  // Per-core halt detection and the exit codes as they will be after this edge.
  // A halted core is held in reset, so the !halted term also drops stores
  // from cores in reset.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    assign halt_hit[g] = (state == RUN) && st_valid[g] && !halted[g] &&
                         (st_addr[g*ADDR_W +: ADDR_W] == HALT_ADDR);
    assign exit_code_nxt[g*DATA_W +: DATA_W] =
      halt_hit[g] ? st_data[g*DATA_W +: DATA_W] : exit_code[g*DATA_W +: DATA_W];
    assign code_ok[g] = (exit_code_nxt[g*DATA_W +: DATA_W] == DATA_W'(1));
  end

  assign halted_nxt     = halted | halt_hit;
  assign all_halted_nxt = &halted_nxt;
  assign codes_ok_nxt   = &code_ok;
  assign budget_end     = (cycle_count == LAST_CYCLE);
  assign cycle_inc      = cycle_count + CNT_W'(1);
  assign state_dbg      = state;

  // Run sequencing FSM; every output is a register updated here.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      cycle_count <= '0;
      halted      <= '0;
      exit_code   <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      pass        <= 1'b0;
      running     <= 1'b0;
      trace_en    <= 1'b0;
      core_reset  <= '1;
    end else begin
      case (state)
        HOLD: begin
          core_reset <= '1;
          running    <= 1'b0;
          if (hold_cnt == HOLD_LAST) begin
            state      <= RUN;
            core_reset <= '0;
            running    <= 1'b1;
            trace_en   <= in_window(cycle_count);
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        RUN: begin
          halted    <= halted_nxt;
          exit_code <= exit_code_nxt;
          if (all_halted_nxt || budget_end) begin
            // A halt on the final budget cycle is already in halted_nxt,
            // so it wins over the timeout.
            state      <= DONE;
            done       <= 1'b1;
            running    <= 1'b0;
            core_reset <= '1;
            trace_en   <= 1'b0;
            timeout    <= !all_halted_nxt;
            pass       <= all_halted_nxt && codes_ok_nxt;
          end else begin
            cycle_count <= cycle_inc;
            core_reset  <= halted_nxt;
            trace_en    <= in_window(cycle_inc);
          end
        end
        DONE: begin
          core_reset <= '1;
          running    <= 1'b0;
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: randomized run scenarios on a 4-core controller checked
// every cycle against an edge-count model, plus a directed run on a
// default-parameter single-core instance.
module tb_mips_run_ctrl;

  localparam int          RC   = 4;
  localparam int          MAXC = 50;
  localparam int          NC   = 4;
  localparam int          CW   = 8;
  localparam int          TS   = 5;
  localparam int          TL   = 3;
  localparam logic [31:0] HALT = 32'hFFFF_FFF0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (4 cores) ----------------
  logic              rst_n = 1'b0;
  logic [NC-1:0]     st_valid = '0;
  logic [NC*32-1:0]  st_addr = '0;
  logic [NC*32-1:0]  st_data = '0;
  logic [NC-1:0]     core_reset;
  logic              running, done, timeout, pass, trace_en;
  logic [NC-1:0]     halted;
  logic [NC*32-1:0]  exit_code;
  logic [CW-1:0]     cycle_count;
  logic [1:0]        state_dbg;

  mips_run_ctrl #(
    .RESET_CYCLES(RC), .MAX_CYCLES(MAXC), .CNT_W(CW), .NUM_CORES(NC),
    .ADDR_W(32), .DATA_W(32), .HALT_ADDR(HALT),
    .TRACE_START(TS), .TRACE_LEN(TL)
  ) dut (
    .clock(clk), .reset(rst_n), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .core_reset(core_reset), .running(running),
    .done(done), .timeout(timeout), .halted(halted), .pass(pass),
    .exit_code(exit_code), .cycle_count(cycle_count), .trace_en(trace_en),
    .state_dbg(state_dbg)
  );

  // ---------------- default DUT (1 core) ----------------
  logic        d_rst = 1'b0;
  logic [0:0]  d_valid = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_data = '0;
  logic [0:0]  d_core_reset, d_halted;
  logic        d_running, d_done, d_timeout, d_pass, d_trace_en;
  logic [31:0] d_exit_code, d_cycle_count;
  logic [1:0]  d_state_dbg;

  mips_run_ctrl dut_d (
    .clock(clk), .reset(d_rst), .st_valid(d_valid), .st_addr(d_addr),
    .st_data(d_data), .core_reset(d_core_reset), .running(d_running),
    .done(d_done), .timeout(d_timeout), .halted(d_halted), .pass(d_pass),
    .exit_code(d_exit_code), .cycle_count(d_cycle_count), .trace_en(d_trace_en),
    .state_dbg(d_state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // k counts edges with reset high since the last reset-low edge; the run
  // starts once RC of them have passed. Halts are recorded per core.
  int               k;
  bit               m_done;
  int               m_stop;
  bit               m_to;
  logic [NC-1:0]    m_halted;
  logic [31:0]      m_code [NC];

  // scenario plan and bookkeeping
  int               plan_cyc [NC];
  logic [31:0]      plan_code [NC];
  int               reset_at;
  int               rst_left;
  int               run_cnt, trace_cnt, post_done;

  function automatic bit m_in_run();
    return (k >= RC) && !m_done;
  endfunction

  function automatic int m_cc();
    if (m_done) return m_stop;
    if (k >= RC) return k - RC;
    return 0;
  endfunction

  task automatic model_reset();
    k = 0; m_done = 0; m_stop = 0; m_to = 0; m_halted = '0;
    for (int i = 0; i < NC; i++) m_code[i] = '0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_in_run()) begin
        int c;
        c = k - RC;
        for (int i = 0; i < NC; i++)
          if (st_valid[i] && st_addr[i*32 +: 32] == HALT && !m_halted[i]) begin
            m_halted[i] = 1'b1;
            m_code[i]   = st_data[i*32 +: 32];
          end
        if ((&m_halted) || c == MAXC - 1) begin
          m_done = 1;
          m_stop = c;
          m_to   = !(&m_halted);
        end
      end
      if (k < 1000) k++;
    end
  endtask

  task automatic compare_main();
    logic [NC-1:0]    ecr;
    logic [NC*32-1:0] ec;
    bit               ok;
    int               cc;
    bit               tr;
    ok = m_done && !m_to;
    for (int i = 0; i < NC; i++) begin
      ec[i*32 +: 32] = m_code[i];
      ecr[i] = m_in_run() ? m_halted[i] : 1'b1;
      if (m_code[i] != 32'd1) ok = 0;
    end
    cc = m_cc();
    tr = m_in_run() && cc >= TS && cc < TS + TL;
    check("core_reset",  core_reset,  ecr);
    check("running",     running,     m_in_run());
    check("done",        done,        m_done);
    check("timeout",     timeout,     m_to);
    check("halted",      halted,      m_halted);
    check("pass",        pass,        ok);
    check("exit_code",   exit_code,   ec);
    check("cycle_count", cycle_count, cc);
    check("trace_en",    trace_en,    tr);
  endtask

  // ---------------- driver ----------------
  function automatic logic [31:0] non_halt_addr();
    logic [31:0] a;
    if ($urandom_range(0, 1) == 1) a = HALT ^ (32'h1 << $urandom_range(0, 31));
    else begin
      a = $urandom;
      if (a == HALT) a = ~a;
    end
    return a;
  endfunction

  task automatic drive_main();
    bit ir;
    int c;
    ir = m_in_run();
    c  = m_cc();
    if (rst_left > 0) begin
      rst_n = 1'b0;
      rst_left--;
    end else if (ir && reset_at >= 0 && c == reset_at) begin
      rst_n = 1'b0;
      reset_at = -1;
      run_cnt = 0;
      trace_cnt = 0;
    end else begin
      rst_n = 1'b1;
    end
    for (int i = 0; i < NC; i++) begin
      logic        v;
      logic [31:0] a, d;
      v = 1'b0;
      a = non_halt_addr();
      d = $urandom;
      if (ir && c == plan_cyc[i]) begin
        v = 1'b1; a = HALT; d = plan_code[i];
      end else if ($urandom_range(0, 3) == 0) begin
        v = 1'b1;
        if ((!ir || m_halted[i]) && $urandom_range(0, 1) == 1) a = HALT;
      end else if ($urandom_range(0, 1) == 1) begin
        a = HALT;
      end
      st_valid[i] = v;
      st_addr[i*32 +: 32] = a;
      st_data[i*32 +: 32] = d;
    end
  endtask

  task automatic step_main();
    @(negedge clk);
    drive_main();
    @(posedge clk);
    model_edge();
    #1;
    compare_main();
    if (running)  run_cnt++;
    if (trace_en) trace_cnt++;
    if (m_done)   post_done++;
  endtask

  task automatic run_scn(input string name, input bit check_counts,
                         input int exp_runs, input int exp_trace);
    rst_left = 2;
    post_done = 0;
    run_cnt = 0;
    trace_cnt = 0;
    for (int n = 0; n < 400 && post_done < 3; n++) step_main();
    if (check_counts) begin
      check({name, "_runs"},  run_cnt,   exp_runs);
      check({name, "_trace"}, trace_cnt, exp_trace);
    end
  endtask

  task automatic set_plan(input int c0, input int c1, input int c2, input int c3,
                          input logic [31:0] k0, input logic [31:0] k1,
                          input logic [31:0] k2, input logic [31:0] k3,
                          input int rat);
    plan_cyc[0] = c0; plan_cyc[1] = c1; plan_cyc[2] = c2; plan_cyc[3] = c3;
    plan_code[0] = k0; plan_code[1] = k1; plan_code[2] = k2; plan_code[3] = k3;
    reset_at = rat;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    reset_at = -1;

    // staggered halts, one bad exit code
    set_plan(10, 20, 20, 30, 1, 1, 7, 1, -1);
    run_scn("stagger", 1, 31, 3);
    check("stagger_cc",    cycle_count, 30);
    check("stagger_pass",  pass, 0);
    check("stagger_code2", exit_code[95:64], 7);
    check("stagger_done",  done, 1);

    // no core ever halts: budget exhausted
    set_plan(-1, -1, -1, -1, 1, 1, 1, 1, -1);
    run_scn("timeout", 1, 50, 3);
    check("timeout_cc",   cycle_count, 49);
    check("timeout_flag", timeout, 1);
    check("timeout_pass", pass, 0);

    // last core halts exactly on the final budget cycle
    set_plan(5, 10, 15, 49, 1, 1, 1, 1, -1);
    run_scn("lasthalt", 1, 50, 3);
    check("lasthalt_to",   timeout, 0);
    check("lasthalt_pass", pass, 1);

    // one core halts on the final cycle, another never does
    set_plan(3, -1, 8, 49, 1, 1, 1, 1, -1);
    run_scn("partial", 1, 50, 3);
    check("partial_to", timeout, 1);

    // mid-run reset at cycle 20, then the same plan runs again to completion
    set_plan(10, 20, 30, 40, 1, 1, 1, 1, 20);
    run_scn("midreset", 1, 41, 3);
    check("midreset_pass", pass, 1);
    check("midreset_cc",   cycle_count, 40);

    // randomized plans
    for (int s = 0; s < 12; s++) begin
      for (int i = 0; i < NC; i++) begin
        plan_cyc[i] = $urandom_range(0, 60);
        case ($urandom_range(0, 3))
          0, 1:    plan_code[i] = 32'd1;
          2:       plan_code[i] = 32'd7;
          default: plan_code[i] = $urandom;
        endcase
      end
      reset_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 45)) : -1;
      run_scn("random", 0, 0, 0);
    end

    // park the main instance in reset while the default instance runs
    @(negedge clk);
    rst_n = 1'b0;

    // ---------------- default-parameter instance ----------------
    d_rst = 1'b0; d_valid = '0; d_addr = '0; d_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("d_rst_creset", d_core_reset, 1);
    check("d_rst_run",    d_running, 0);
    check("d_rst_done",   d_done, 0);
    check("d_rst_cc",     d_cycle_count, 0);
    check("d_rst_code",   d_exit_code, 0);
    check("d_rst_trace",  d_trace_en, 0);

    // release; a halt store during HOLD must be ignored
    d_rst = 1'b1; d_valid = 1'b1; d_addr = HALT; d_data = 32'd5;
    @(posedge clk); #1;
    check("d_hold1_creset", d_core_reset, 1);
    check("d_hold1_run",    d_running, 0);
    @(negedge clk);
    @(posedge clk); #1;
    check("d_entry_creset", d_core_reset, 0);
    check("d_entry_run",    d_running, 1);
    check("d_entry_cc",     d_cycle_count, 0);
    check("d_entry_trace",  d_trace_en, 1);
    check("d_entry_halted", d_halted, 0);
    check("d_entry_code",   d_exit_code, 0);

    for (int c = 0; c <= 100; c++) begin
      @(negedge clk);
      d_valid = 1'b0; d_addr = $urandom; d_data = 32'd1;
      if (c == 50) begin d_valid = 1'b1; d_addr = HALT ^ 32'h10; end
      if (c == 60) begin d_valid = 1'b0; d_addr = HALT; end
      if (c == 70) begin d_valid = 1'b1; d_addr = non_halt_addr(); end
      if (c == 100) begin d_valid = 1'b1; d_addr = HALT; d_data = 32'd1; end
      @(posedge clk); #1;
      if (c < 100) begin
        check("d_run_cc",     d_cycle_count, c + 1);
        check("d_run_trace",  d_trace_en, 1);
        check("d_run_halted", d_halted, 0);
        check("d_run_run",    d_running, 1);
      end
    end
    check("d_end_halted", d_halted, 1);
    check("d_end_code",   d_exit_code, 1);
    check("d_end_done",   d_done, 1);
    check("d_end_pass",   d_pass, 1);
    check("d_end_to",     d_timeout, 0);
    check("d_end_cc",     d_cycle_count, 100);
    check("d_end_run",    d_running, 0);
    check("d_end_creset", d_core_reset, 1);
    check("d_end_trace",  d_trace_en, 0);

    @(negedge clk);
    d_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("d_hold_done", d_done, 1);
    check("d_hold_cc",   d_cycle_count, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
